// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    WAIT   = 3'd1,
    HOLD   = 3'd2,
    HALTED = 3'd3,
    ERROR  = 3'd4
  } fetch_state_t;

  // Bytes per instruction word; the sequential PC step.
  localparam int INSTR_BYTES = 4;

  // How the retiring instruction redirects the PC.
  typedef enum logic [1:0] {
    RD_SEQ    = 2'd0,
    RD_BRANCH = 2'd1,
    RD_JAL    = 2'd2,
    RD_HALT   = 2'd3
  } redirect_kind_t;

  // Resolve the redirect flags with priority halt > branch > jal > sequential.
  function automatic redirect_kind_t redirect_kind(input logic halt,
                                                   input logic branch,
                                                   input logic jal);
    redirect_kind_t k;
    if (halt)        k = RD_HALT;
    else if (branch) k = RD_BRANCH;
    else if (jal)    k = RD_JAL;
    else             k = RD_SEQ;
    return k;
  endfunction

endpackage

// File: rtl/fetch_controller_next_pc.sv
// Combinational next-PC selection and target alignment check for the
// instruction being retired.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr_pc,
  input  logic            is_halt,
  input  logic            branch_taken,
  input  logic            is_jal,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] imm_j,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned,
  output redirect_kind_t  kind
);

  // Pick the successor PC (modulo 2^XLEN) and flag a non-word-aligned target.
  // A halt keeps the current PC and can never be misaligned.
  always_comb begin
    kind       = redirect_kind(is_halt, branch_taken, is_jal);
    next_pc    = instr_pc;
    case (kind)
      RD_HALT:   next_pc = instr_pc;
      RD_BRANCH: next_pc = branch_target;
      RD_JAL:    next_pc = instr_pc + imm_j;
      default:   next_pc = instr_pc + XLEN'(INSTR_BYTES);
    endcase
    misaligned = (kind != RD_HALT) && (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a
// time, presents the fetched word to decode and applies the redirect that
// decode/execute resolves in the acceptance cycle.
//
// Handshakes: imem request transfers on a cycle where imem_req && imem_ready;
// the response is only taken while in WAIT (imem_rvalid elsewhere is dropped).
// Decode transfer happens on a cycle where instr_valid && instr_ready; once
// instr_valid is high, instr_data/instr_pc hold steady until that cycle, and
// the redirect inputs are only looked at in that cycle.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 15
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            is_halt,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            is_jal,
  input  logic [XLEN-1:0] imm_j,
  output logic            halted,
  output logic            fetch_error,
  output logic [2:0]      dbg_state
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [XLEN-1:0] instr_data_q, instr_data_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;

  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  redirect_kind_t  kind;

  fetch_next_pc #(
    .XLEN (XLEN)
  ) u_next_pc (
    .instr_pc      (instr_pc_q),
    .is_halt       (is_halt),
    .branch_taken  (branch_taken),
    .is_jal        (is_jal),
    .branch_target (branch_target),
    .imm_j         (imm_j),
    .next_pc       (next_pc),
    .misaligned    (misaligned),
    .kind          (kind)
  );

  // State and datapath registers; reset puts the sequencer back at RESET_PC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      wait_cnt_q   <= '0;
      instr_data_q <= '0;
      instr_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wait_cnt_q   <= wait_cnt_d;
      instr_data_q <= instr_data_d;
      instr_pc_q   <= instr_pc_d;
    end
  end

  // Next-state logic: request, wait (with timeout), hold for decode, retire.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    wait_cnt_d   = wait_cnt_q;
    instr_data_d = instr_data_q;
    instr_pc_d   = instr_pc_q;
    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_data_d = imem_rdata;
          instr_pc_d   = pc_q;
          state_d      = HOLD;
        end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          // MAX_WAIT cycles spent in WAIT with no response.
          wait_cnt_d = CNT_W'(MAX_WAIT);
          state_d    = ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (instr_ready) begin
          if (kind == RD_HALT) begin
            state_d = HALTED;
          end else if (misaligned) begin
            // Trap before the bad target ever reaches the PC or the bus.
            state_d = ERROR;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      HALTED:  state_d = HALTED;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  // No request may leave while reset is held, even though state reads FETCH.
  assign imem_req    = reset && (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr_data  = instr_data_q;
  assign instr_pc    = instr_pc_q;
  assign halted      = (state_q == HALTED);
  assign fetch_error = (state_q == ERROR);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: driver tasks play memory and decode,
// keep a transaction-level expectation of the outputs, and a per-cycle
// compare process checks the DUT against it.
module tb_fetch_controller;

  localparam int MAXW = 15;

  logic        clock;
  logic        reset;
  logic        imem_ready, imem_rvalid, instr_ready;
  logic        is_halt, branch_taken, is_jal;
  logic [31:0] imem_rdata, branch_target, imm_j;

  logic        imem_req, instr_valid, halted, fetch_error;
  logic [31:0] imem_addr, instr_data, instr_pc;
  logic [2:0]  dbg_state;

  logic        imem_req2, instr_valid2, halted2, fetch_error2;
  logic [31:0] imem_addr2, instr_data2, instr_pc2;
  logic [2:0]  dbg_state2;

  // Expected view of the DUT outputs
  logic        chk_en;
  logic        exp_req, exp_valid, exp_halted, exp_err;
  logic [31:0] exp_pc, exp_data, exp_ipc;

  int n_total;
  int n_pass;

  fetch_controller #(.XLEN(32), .RESET_PC(32'h0), .MAX_WAIT(MAXW)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .is_halt(is_halt), .branch_taken(branch_taken), .branch_target(branch_target),
    .is_jal(is_jal), .imm_j(imm_j),
    .halted(halted), .fetch_error(fetch_error), .dbg_state(dbg_state)
  );

  // Second instance with a reset PC at the top of the address space
  fetch_controller #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(MAXW)) dut2 (
    .clock(clock), .reset(reset),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid2), .instr_ready(instr_ready),
    .instr_data(instr_data2), .instr_pc(instr_pc2),
    .is_halt(is_halt), .branch_taken(branch_taken), .branch_target(branch_target),
    .is_jal(is_jal), .imm_j(imm_j),
    .halted(halted2), .fetch_error(fetch_error2), .dbg_state(dbg_state2)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the expected view
  always @(negedge clock) begin
    if (chk_en) begin
      check("imem_req",    32'(imem_req),    32'(exp_req));
      check("imem_addr",   imem_addr,        exp_pc);
      check("instr_valid", 32'(instr_valid), 32'(exp_valid));
      check("halted",      32'(halted),      32'(exp_halted));
      check("fetch_error", 32'(fetch_error), 32'(exp_err));
      if (exp_valid) begin
        check("instr_data", instr_data, exp_data);
        check("instr_pc",   instr_pc,   exp_ipc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ready    = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    instr_ready   = 1'b0;
    is_halt       = 1'b0;
    branch_taken  = 1'b0;
    is_jal        = 1'b0;
    branch_target = 32'h0;
    imm_j         = 32'h0;
  endtask

  task automatic expect_reset_values();
    exp_req    = 1'b0;
    exp_valid  = 1'b0;
    exp_halted = 1'b0;
    exp_err    = 1'b0;
    exp_pc     = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    expect_reset_values();
    step();
    step();
    reset   = 1'b1;
    exp_req = 1'b1;
  endtask

  // One full instruction: request accepted, response after rv_delay WAIT
  // cycles, held hold cycles (with redirect noise while not accepted), then
  // accepted with the given redirect flags.
  task automatic run_instr(input logic [31:0] rdata, input int rv_delay, input int hold,
                           input logic halt, input logic br, input logic jal,
                           input logic [31:0] tgt, input logic [31:0] imm);
    logic [31:0] nxt;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    exp_req    = 1'b0;
    repeat (rv_delay) step();
    imem_rvalid = 1'b1;
    imem_rdata  = rdata;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    exp_valid   = 1'b1;
    exp_data    = rdata;
    exp_ipc     = exp_pc;
    repeat (hold) begin
      instr_ready   = 1'b0;
      is_halt       = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0042;
      imem_rvalid   = 1'($urandom_range(0, 1));
      step();
    end
    imem_rvalid   = 1'b0;
    instr_ready   = 1'b1;
    is_halt       = halt;
    branch_taken  = br;
    is_jal        = jal;
    branch_target = tgt;
    imm_j         = imm;
    step();
    clear_inputs();
    exp_valid = 1'b0;
    if (halt) begin
      exp_halted = 1'b1;
    end else begin
      if (br)       nxt = tgt;
      else if (jal) nxt = exp_ipc + imm;
      else          nxt = exp_ipc + 32'd4;
      if (nxt[1:0] != 2'b00) exp_err = 1'b1;
      else begin
        exp_pc  = nxt;
        exp_req = 1'b1;
      end
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    chk_en  = 1'b0;
    clear_inputs();
    expect_reset_values();
    exp_data = 32'h0;
    exp_ipc  = 32'h0;
    reset    = 1'b1;
    #2;
    reset  = 1'b0;
    chk_en = 1'b1;
    do_reset();
    check("reset_addr",      imem_addr,  32'h0);
    check("dut2_reset_addr", imem_addr2, 32'hFFFF_FFFC);

    // Sequential stream: 0, 4, 8, C, 10
    run_instr(32'h0050_0093, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    check("seq_addr_4",     imem_addr,  32'h4);
    check("dut2_wrap_addr", imem_addr2, 32'h0);
    run_instr(32'h0050_0093, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    check("seq_addr_8", imem_addr, 32'h8);
    run_instr(32'h0010_0113, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    run_instr(32'h0020_0193, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    check("seq_addr_10", imem_addr, 32'h10);

    // Branch beats JAL
    run_instr(32'h0400_0063, 0, 0, 0, 1, 1, 32'h40, 32'h0000_0100);
    check("branch_over_jal", imem_addr, 32'h40);
    run_instr(32'hFE1F_F06F, 0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFE0);
    check("jal_back_20", imem_addr, 32'h20);
    run_instr(32'hFF1F_F06F, 0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFF0);
    check("jal_neg_10", imem_addr, 32'h10);
    run_instr(32'hFEDF_F06F, 3, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFEC);
    check("jal_top", imem_addr, 32'hFFFF_FFFC);
    run_instr(32'h0000_0013, 0, 2, 0, 0, 0, 32'h0, 32'h0);
    check("seq_wrap_0", imem_addr, 32'h0);

    // Stall 5 cycles, then halt (beats branch)
    run_instr(32'h0000_0073, 0, 5, 1, 1, 0, 32'h80, 32'h0);
    repeat (4) step();
    check("halted_sticky", 32'(halted),   32'h1);
    check("halted_no_req", 32'(imem_req), 32'h0);
    check("halted_pc",     imem_addr,     32'h0);

    // Memory timeout
    do_reset();
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    exp_req    = 1'b0;
    repeat (MAXW - 1) step();
    step();
    exp_err = 1'b1;
    repeat (3) step();
    check("timeout_err",    32'(fetch_error), 32'h1);
    check("timeout_no_req", 32'(imem_req),    32'h0);

    // Misaligned branch target
    do_reset();
    run_instr(32'h0420_0063, 0, 0, 0, 1, 0, 32'h42, 32'h0);
    repeat (3) step();
    check("misalign_err",    32'(fetch_error), 32'h1);
    check("misalign_no_req", 32'(imem_req),    32'h0);
    check("misalign_pc",     imem_addr,        32'h0);

    // Reset in the middle of WAIT, then a late response during FETCH
    do_reset();
    run_instr(32'h0050_0093, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    exp_req    = 1'b0;
    step();
    step();
    reset = 1'b0;
    expect_reset_values();
    step();
    check("rst_mid_req",   32'(imem_req),    32'h0);
    check("rst_mid_valid", 32'(instr_valid), 32'h0);
    check("rst_mid_data",  instr_data,       32'h0);
    check("rst_mid_ipc",   instr_pc,         32'h0);
    step();
    reset       = 1'b1;
    exp_req     = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    step();
    imem_rvalid = 1'b0;
    check("stale_rvalid_valid", 32'(instr_valid), 32'h0);
    check("stale_rvalid_addr",  imem_addr,        32'h0);
    run_instr(32'h1234_5678, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    check("after_stale_addr", imem_addr, 32'h4);
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
